// File: rtl/fll_freq_seq.sv
// fll_freq_seq: read-modify-write of FLL config register 1 to change the multiplication factor, then wait for stable lock.
module fll_freq_seq #(
    parameter int LOCK_TIMEOUT = 4096,
    parameter int LOCK_STABLE  = 16
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        chg_req,
    input  logic [15:0] chg_mult,
    output logic        chg_busy,
    output logic        chg_done,
    output logic        chg_err,
    output logic        fll_req,
    output logic        fll_wrn,
    output logic [1:0]  fll_add,
    output logic [31:0] fll_data,
    input  logic        fll_ack,
    input  logic [31:0] fll_r_data,
    input  logic        fll_lock
);
    localparam int TW = $clog2(LOCK_TIMEOUT) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [7:0] STAB_DONE = 8'(LOCK_STABLE);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_REL, WR_REQ, WR_REL, LOCK_WAIT} state_t;

    state_t        r_state;
    logic          r_ack_m, r_ack_s, r_lock_m, r_lock_s;
    logic [15:0]   r_mult, r_cfg_hi;
    logic [TW-1:0] r_tmo;
    logic [7:0]    r_stab;
    logic [TW-1:0] w_tmo_nxt;
    logic [7:0]    w_stab_nxt;
    logic          w_unused;

    // The low half of register 1 is replaced by the new factor, so its read value is never needed.
    assign w_unused   = ^fll_r_data[15:0];
    assign w_tmo_nxt  = (r_tmo == '1) ? r_tmo : r_tmo + 1'b1;
    assign w_stab_nxt = !r_lock_s ? 8'd0 : (r_stab == 8'hFF) ? r_stab : r_stab + 8'd1;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state  <= IDLE;
            r_ack_m  <= 1'b0;
            r_ack_s  <= 1'b0;
            r_lock_m <= 1'b0;
            r_lock_s <= 1'b0;
            r_mult   <= '0;
            r_cfg_hi <= '0;
            r_tmo    <= '0;
            r_stab   <= '0;
            chg_busy <= 1'b0;
            chg_done <= 1'b0;
            chg_err  <= 1'b0;
            fll_req  <= 1'b0;
            fll_wrn  <= 1'b0;
            fll_add  <= 2'b00;
            fll_data <= '0;
        end else begin
            r_ack_m  <= fll_ack;
            r_ack_s  <= r_ack_m;
            r_lock_m <= fll_lock;
            r_lock_s <= r_lock_m;
            chg_done <= 1'b0;
            chg_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    chg_busy <= 1'b0;
                    if (chg_req && !chg_done && !chg_err) begin
                        r_mult   <= chg_mult;
                        chg_busy <= 1'b1;
                        fll_req  <= 1'b1;
                        fll_wrn  <= 1'b1;
                        fll_add  <= 2'b01;
                        r_state  <= RD_REQ;
                    end
                end
                RD_REQ: if (r_ack_s) begin
                    r_cfg_hi <= fll_r_data[31:16];
                    fll_req  <= 1'b0;
                    fll_wrn  <= 1'b0;
                    fll_add  <= 2'b00;
                    r_state  <= RD_REL;
                end
                RD_REL: if (!r_ack_s) begin
                    fll_req  <= 1'b1;
                    fll_add  <= 2'b01;
                    fll_data <= {r_cfg_hi, r_mult};
                    r_state  <= WR_REQ;
                end
                WR_REQ: if (r_ack_s) begin
                    fll_req  <= 1'b0;
                    fll_add  <= 2'b00;
                    fll_data <= '0;
                    r_state  <= WR_REL;
                end
                WR_REL: if (!r_ack_s) begin
                    r_tmo   <= '0;
                    r_stab  <= '0;
                    r_state <= LOCK_WAIT;
                end
                LOCK_WAIT: begin
                    r_tmo  <= w_tmo_nxt;
                    r_stab <= w_stab_nxt;
                    // Lock success is tested first so it wins a same-cycle tie with the timeout.
                    if (w_stab_nxt == STAB_DONE) begin
                        chg_done <= 1'b1;
                        r_state  <= IDLE;
                    end else if (r_tmo == TMO_LAST) begin
                        chg_err <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fll_freq_seq.sv
// tb_fll_freq_seq: directed checks of the FLL frequency-change sequencer against a delayed-ack FLL model.
module tb_fll_freq_seq;
    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b1;
    logic        chg_req = 1'b0;
    logic [15:0] chg_mult = 16'h0;
    logic        chg_busy, chg_done, chg_err, fll_req, fll_wrn, fll_ack;
    logic [1:0]  fll_add;
    logic [31:0] fll_data;
    logic [31:0] fll_r_data = 32'hA5A5_0010;
    logic        fll_lock = 1'b1;
    logic [2:0]  r_dly = 3'b000;

    logic        t_req = 1'b0;
    logic        t_busy, t_done, t_err, t_freq, t_wrn;
    logic [1:0]  t_add;
    logic [31:0] t_data;

    int cyc = 0;
    int n_chk = 0, n_fail = 0;
    int n_rd = 0, n_wr = 0, n_done = 0, n_err = 0, n_bad = 0;
    int rd0, wr0, dn0, er0;
    logic        prev_req = 1'b0;
    logic [34:0] held = '0;
    logic [1:0]  rd_add = 2'b00, wr_add = 2'b00;
    logic [31:0] wr_data = '0;

    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc <= cyc + 1;
    // FLL model: ack follows req three cycles later.
    always @(posedge HCLK) r_dly <= {r_dly[1:0], fll_req};
    assign fll_ack = r_dly[2];

    fll_freq_seq #(.LOCK_TIMEOUT(64), .LOCK_STABLE(16)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .chg_req(chg_req), .chg_mult(chg_mult),
        .chg_busy(chg_busy), .chg_done(chg_done), .chg_err(chg_err),
        .fll_req(fll_req), .fll_wrn(fll_wrn), .fll_add(fll_add), .fll_data(fll_data),
        .fll_ack(fll_ack), .fll_r_data(fll_r_data), .fll_lock(fll_lock)
    );

    // Second instance where stable lock and timeout land on the same edge.
    fll_freq_seq #(.LOCK_TIMEOUT(64), .LOCK_STABLE(64)) dut_tie (
        .HCLK(HCLK), .HRESETn(HRESETn), .chg_req(t_req), .chg_mult(16'h0042),
        .chg_busy(t_busy), .chg_done(t_done), .chg_err(t_err),
        .fll_req(t_freq), .fll_wrn(t_wrn), .fll_add(t_add), .fll_data(t_data),
        .fll_ack(t_freq), .fll_r_data(32'h1234_0000), .fll_lock(1'b1)
    );

    always @(negedge HCLK) begin
        if (fll_req && !prev_req) begin
            held <= {fll_wrn, fll_add, fll_data};
            if (fll_wrn) begin
                n_rd   <= n_rd + 1;
                rd_add <= fll_add;
            end else begin
                n_wr    <= n_wr + 1;
                wr_add  <= fll_add;
                wr_data <= fll_data;
            end
        end
        if ((fll_req && prev_req && {fll_wrn, fll_add, fll_data} !== held) ||
            (fll_req && fll_add !== 2'b01) ||
            (!fll_req && {fll_wrn, fll_add, fll_data} !== 35'd0))
            n_bad <= n_bad + 1;
        if (chg_done) n_done <= n_done + 1;
        if (chg_err) n_err <= n_err + 1;
        prev_req <= fll_req;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [15:0] m, output int n);
        @(negedge HCLK);
        chg_req  = 1'b1;
        chg_mult = m;
        @(negedge HCLK);
        chg_req = 1'b0;
        n = cyc;
        chk("accept_busy", 32'(chg_busy), 32'd1);
        chk("accept_read", 32'({fll_req, fll_wrn, fll_add}), 32'b1101);
    endtask

    task automatic wait_wr_end(output int w);
        int k;
        for (k = 0; k < 200 && !(fll_req && !fll_wrn); k++) @(negedge HCLK);
        for (; k < 200 && fll_req; k++) @(negedge HCLK);
        w = cyc;
        chk("write_bound", 32'(k < 200), 32'd1);
    endtask

    task automatic wait_end(output int t, output int lows);
        int k;
        lows = 0;
        for (k = 0; k < 300 && !(chg_done || chg_err); k++) begin
            if (!chg_busy) lows++;
            @(negedge HCLK);
        end
        t = cyc;
        chk("end_bound", 32'(k < 300), 32'd1);
    endtask

    task automatic snap();
        rd0 = n_rd;
        wr0 = n_wr;
        dn0 = n_done;
        er0 = n_err;
    endtask

    task automatic counts(input int rd, input int wr, input int dn, input int er);
        repeat (4) @(negedge HCLK);
        chk("n_read", n_rd - rd0, rd);
        chk("n_write", n_wr - wr0, wr);
        chk("n_done", n_done - dn0, dn);
        chk("n_err", n_err - er0, er);
    endtask

    task automatic after_pulse();
        @(negedge HCLK);
        chk("busy_fall", 32'({chg_busy, chg_done, chg_err}), 32'd0);
    endtask

    initial begin
        int n, w, t, lows, tg, k;
        #1 HRESETn = 1'b0;
        @(negedge HCLK);
        chk("reset_ctl", 32'({fll_req, fll_wrn, fll_add, chg_busy, chg_done, chg_err}), 32'd0);
        chk("reset_data", fll_data, 32'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (4) @(negedge HCLK);

        // Nominal change with lock already high.
        snap();
        start(16'h0123, n);
        wait_wr_end(w);
        wait_end(t, lows);
        chk("nom_done", 32'({chg_done, chg_err}), 32'b10);
        chk("nom_busy_held", lows, 0);
        chk("nom_lat_wr", t - w, 22);
        chk("nom_lat_req", t - n, 40);
        after_pulse();
        counts(1, 1, 1, 0);
        chk("nom_rd_add", 32'(rd_add), 32'd1);
        chk("nom_wr_add", 32'(wr_add), 32'd1);
        chk("nom_wr_data", wr_data, 32'hA5A5_0123);

        // Lock never arrives.
        fll_lock = 1'b0;
        snap();
        start(16'h0200, n);
        wait_wr_end(w);
        wait_end(t, lows);
        chk("tmo_err", 32'({chg_done, chg_err}), 32'b01);
        chk("tmo_lat", t - w, 70);
        after_pulse();
        counts(1, 1, 0, 1);
        chk("tmo_wr_data", wr_data, 32'hA5A5_0200);

        // Single-cycle lock glitch restarts the stable count.
        snap();
        start(16'h0300, n);
        wait_wr_end(w);
        repeat (6) @(negedge HCLK);
        fll_lock = 1'b1;
        tg = cyc;
        repeat (10) @(negedge HCLK);
        fll_lock = 1'b0;
        @(negedge HCLK);
        fll_lock = 1'b1;
        wait_end(t, lows);
        chk("glitch_done", 32'({chg_done, chg_err}), 32'b10);
        chk("glitch_lat", t - tg, 29);
        after_pulse();
        counts(1, 1, 1, 0);

        // Second request during the write access is dropped.
        snap();
        start(16'h0123, n);
        for (k = 0; k < 200 && !(fll_req && !fll_wrn); k++) @(negedge HCLK);
        chg_req  = 1'b1;
        chg_mult = 16'h0456;
        @(negedge HCLK);
        chg_req = 1'b0;
        wait_wr_end(w);
        wait_end(t, lows);
        chk("busy_req_done", 32'({chg_done, chg_err}), 32'b10);
        after_pulse();
        repeat (20) @(negedge HCLK);
        counts(1, 1, 1, 0);
        chk("busy_req_data", wr_data, 32'hA5A5_0123);

        // Asynchronous reset while the read request is outstanding.
        start(16'h0789, n);
        #2 HRESETn = 1'b0;
        #1 chk("rst_async", 32'({fll_req, chg_busy, fll_wrn, fll_add}), 32'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (8) @(negedge HCLK);
        snap();
        start(16'h0ABC, n);
        wait_wr_end(w);
        wait_end(t, lows);
        chk("rst_rerun_done", 32'({chg_done, chg_err}), 32'b10);
        after_pulse();
        counts(1, 1, 1, 0);
        chk("rst_rerun_data", wr_data, 32'hA5A5_0ABC);

        // Stable lock and timeout on the same edge: done must win.
        @(negedge HCLK);
        t_req = 1'b1;
        @(negedge HCLK);
        t_req = 1'b0;
        n = cyc;
        for (k = 0; k < 300 && !(t_done || t_err); k++) @(negedge HCLK);
        chk("tie_done", 32'({t_done, t_err, t_busy}), 32'b101);
        chk("tie_lat", cyc - n, 76);
        repeat (2) @(negedge HCLK);
        chk("tie_idle", 32'({t_freq, t_wrn, t_add}) | t_data, 32'd0);
        chk("tie_no_err", 32'(t_err), 32'd0);

        chk("handshake_hold", n_bad, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
